// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and sizes for the register-file access controller
// Contents: rf_op_e request opcodes, ctrl_state_e sequencer states, register-file geometry.
package rf_ctrl_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_REG_W    = 3;
    localparam int RF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD1 = 2'b01,
        OP_RD2 = 2'b10,
        OP_WR  = 2'b11
    } rf_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_RESP
    } ctrl_state_e;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// rtl/rf_access_ctrl_if.sv - requester-side request/grant/response bus of rf_access_ctrl
// Signals: req/req_op/req_ra/req_rb/req_wdata (packed per requester), gnt (one-hot),
//          rsp_valid/rsp_id/rsp_a/rsp_b (response pulse), busy.
// Modports: master = requester side, slave = controller side.
interface rf_access_ctrl_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_op;
    logic [REG_W*N_REQ-1:0]  req_ra;
    logic [REG_W*N_REQ-1:0]  req_rb;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [DATA_W-1:0]       rsp_a;
    logic [DATA_W-1:0]       rsp_b;
    logic                    busy;

    modport master (
        output req, req_op, req_ra, req_rb, req_wdata,
        input  gnt, rsp_valid, rsp_id, rsp_a, rsp_b, busy
    );

    modport slave (
        input  req, req_op, req_ra, req_rb, req_wdata,
        output gnt, rsp_valid, rsp_id, rsp_a, rsp_b, busy
    );
endinterface

// File: rtl/rf_req_arbiter.sv
// rtl/rf_req_arbiter.sv - picks one requester while the controller is idle
// Ports: clk, reset (sync, active-high), en (controller idle), req[N_REQ],
//        gnt[N_REQ] one-hot (combinational), gnt_idx winner index.
// Build option RF_CTRL_RR_EN: round-robin starting after the last winner;
// otherwise fixed priority with requester 0 highest.
module rf_req_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx
);

`ifdef RF_CTRL_RR_EN
    logic [1:0] ptr;

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'(N_REQ - 1);
        end else if (|gnt) begin
            ptr <= gnt_idx;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
`endif

    always_comb begin
        logic [N_REQ-1:0] sh;
        int               k;
        gnt     = '0;
        gnt_idx = '0;
        sh      = '0;
        k       = 0;
        if (en) begin
            // Walk from lowest to highest priority so the last hit is the winner.
            for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef RF_CTRL_RR_EN
                k = (int'(ptr) + 1 + i) % N_REQ;
`else
                k = i;
`endif
                sh = req >> k;
                if (sh[0]) begin
                    gnt     = N_REQ'(1) << k;
                    gnt_idx = 2'(k);
                end
            end
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - sequencer/arbiter for a single-port 8x16 register file
// Ports: clk, reset (sync, active-high), bus (rf_access_ctrl_if.slave: req/gnt/rsp),
//        rf_reg_num/rf_rd_wr/rf_d_in to the register file, rf_d_out from it (combinational).
// One transaction at a time: WR, RD1, RD2 (two cycles) or NOP; response pulse in RESP.
// Build option RF_CTRL_RR_EN selects round-robin arbitration (see rf_req_arbiter).
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = RF_DATA_W,
    parameter int REG_W  = RF_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    rf_access_ctrl_if.slave   bus,
    output logic [REG_W-1:0]  rf_reg_num,
    output logic              rf_rd_wr,
    output logic [DATA_W-1:0] rf_d_in,
    input  logic [DATA_W-1:0] rf_d_out
);

    // Per-requester fields unpacked into 4-entry tables so a 2-bit index is always in range.
    logic [1:0]        op_arr [4];
    logic [REG_W-1:0]  ra_arr [4];
    logic [REG_W-1:0]  rb_arr [4];
    logic [DATA_W-1:0] wd_arr [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        if (i < N_REQ) begin : g_on
            assign op_arr[i] = bus.req_op[2*i +: 2];
            assign ra_arr[i] = bus.req_ra[REG_W*i +: REG_W];
            assign rb_arr[i] = bus.req_rb[REG_W*i +: REG_W];
            assign wd_arr[i] = bus.req_wdata[DATA_W*i +: DATA_W];
        end else begin : g_off
            assign op_arr[i] = '0;
            assign ra_arr[i] = '0;
            assign rb_arr[i] = '0;
            assign wd_arr[i] = '0;
        end
    end

    ctrl_state_e       state;
    rf_op_e            op_q;
    logic [REG_W-1:0]  rb_q;
    logic [1:0]        id_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              rsp_valid_q;
    logic              busy_q;
    logic [N_REQ-1:0]  gnt;
    logic [1:0]        win_idx;
    rf_op_e            win_op;

    rf_req_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (state == ST_IDLE),
        .req     (bus.req),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign win_op        = rf_op_e'(op_arr[win_idx]);
    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_a     = a_q;
    assign bus.rsp_b     = b_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_NOP;
            rb_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rf_reg_num  <= '0;
            rf_rd_wr    <= 1'b0;
            rf_d_in     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rf_rd_wr    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        op_q       <= win_op;
                        rb_q       <= rb_arr[win_idx];
                        id_q       <= win_idx;
                        a_q        <= '0;
                        b_q        <= '0;
                        busy_q     <= 1'b1;
                        // Port address/data are set up at the grant edge so the
                        // next state sees them stable for its whole cycle.
                        rf_reg_num <= ra_arr[win_idx];
                        rf_d_in    <= (win_op == OP_WR) ? wd_arr[win_idx] : '0;
                        unique case (win_op)
                            OP_RD1, OP_RD2: state <= ST_RD_A;
                            OP_WR: begin
                                state    <= ST_WR;
                                rf_rd_wr <= 1'b1;
                            end
                            OP_NOP: begin
                                state       <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD_A: begin
                    a_q <= rf_d_out;
                    if (op_q == OP_RD2) begin
                        state      <= ST_RD_B;
                        rf_reg_num <= rb_q;
                    end else begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RD_B: begin
                    b_q         <= rf_d_out;
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_WR: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    a_q    <= '0;
                    b_q    <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb/tb_rf_access_ctrl.sv - self-checking bench for rf_access_ctrl with a behavioural register-file model
module tb_rf_access_ctrl;
    import rf_ctrl_pkg::*;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rf_reg_num;
    logic        rf_rd_wr;
    logic [15:0] rf_d_in;
    logic [15:0] rf_d_out;

    always #5 clk = ~clk;

    rf_access_ctrl_if #(.N_REQ(N), .DATA_W(16), .REG_W(3)) bus ();

    rf_access_ctrl #(.N_REQ(N), .DATA_W(16), .REG_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .rf_reg_num (rf_reg_num),
        .rf_rd_wr   (rf_rd_wr),
        .rf_d_in    (rf_d_in),
        .rf_d_out   (rf_d_out)
    );

    // Physical register file attached to the DUT port.
    logic [15:0] mem [8];
    assign rf_d_out = mem[rf_reg_num];
    always @(posedge clk) if (rf_rd_wr) mem[rf_reg_num] <= rf_d_in;

    // Reference model state.
    logic [15:0] ref_rf [8];
    int          ptr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        if ($countones(g) != 1) return -1;
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int exp_winner(input logic [N-1:0] r);
`ifdef RF_CTRL_RR_EN
        for (int i = 1; i <= N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    task automatic set_fields(input int id, input logic [1:0] op, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [15:0] wd);
        bus.req_op[2*id +: 2]     = op;
        bus.req_ra[3*id +: 3]     = ra;
        bus.req_rb[3*id +: 3]     = rb;
        bus.req_wdata[16*id +: 16] = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptr   = N - 1;
    endtask

    task automatic run_txn(input int id, input logic [1:0] op, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [15:0] wd);
        logic [15:0] ea, eb;
        int lat, nwr, w;
        ea = '0;
        eb = '0;
        if (op == 2'b01) ea = ref_rf[ra];
        if (op == 2'b10) begin
            ea = ref_rf[ra];
            eb = ref_rf[rb];
        end
        @(negedge clk);
        set_fields(id, op, ra, rb, wd);
        bus.req[id] = 1'b1;
        #1;
        for (int c = 0; c < 20 && bus.gnt == '0; c++) begin
            @(negedge clk);
            #1;
        end
        check_eq("gnt_seen", 32'(bus.gnt != '0), 1);
        w = onehot_idx(bus.gnt);
        check_eq("gnt_winner", w, exp_winner(bus.req));
        ptr = w;
        if (op == 2'b11) ref_rf[ra] = wd;
        @(posedge clk);
        #1 bus.req[id] = 1'b0;
        lat = 0;
        nwr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (rf_rd_wr) nwr++;
            if (bus.rsp_valid) break;
        end
        check_eq("rsp_latency", lat, exp_lat(op));
        check_eq("rsp_id", bus.rsp_id, id);
        check_eq("rsp_a", bus.rsp_a, ea);
        check_eq("rsp_b", bus.rsp_b, eb);
        check_eq("wr_cycles", nwr, (op == 2'b11) ? 1 : 0);
        @(negedge clk);
        check_eq("rsp_pulse", bus.rsp_valid, 0);
        check_eq("busy_done", bus.busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got, w, nrsp;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_ra    = '0;
        bus.req_rb    = '0;
        bus.req_wdata = '0;
        ptr           = N - 1;

        // Reset state.
        do_reset();
        @(negedge clk);
        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_id", bus.rsp_id, 0);
        check_eq("rst_rsp_a", bus.rsp_a, 0);
        check_eq("rst_rsp_b", bus.rsp_b, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_rf_rd_wr", rf_rd_wr, 0);
        check_eq("rst_rf_reg_num", rf_reg_num, 0);
        check_eq("rst_rf_d_in", rf_d_in, 0);

        // Preload every register through the controller.
        for (int r = 0; r < 8; r++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (r == 1) v = 16'h0011;
            if (r == 6) v = 16'h0066;
            if (r == 7) v = 16'h7777;
            run_txn(r % N, 2'b11, 3'(r), 3'd0, v);
        end

        // Write then read back from another requester.
        run_txn(0, 2'b11, 3'd3, 3'd0, 16'hBEEF);
        run_txn(1, 2'b01, 3'd3, 3'd0, 16'h0000);
        check_eq("r3_model", ref_rf[3], 16'hBEEF);

        // Two-operand read, NOP, same-register two-operand read.
        run_txn(0, 2'b10, 3'd1, 3'd6, 16'h0);
        run_txn(1, 2'b00, 3'd2, 3'd5, 16'h1234);
        run_txn(1, 2'b10, 3'd7, 3'd7, 16'h0);

        // Reset in the cycle after a write grant: transaction aborted.
        @(negedge clk);
        set_fields(0, 2'b11, 3'd5, 3'd0, 16'hA5A5);
        bus.req[0] = 1'b1;
        #1;
        check_eq("abort_gnt", bus.gnt, 2'b01);
        @(posedge clk);
        #1;
        bus.req[0] = 1'b0;
        reset      = 1'b1;
        nrsp       = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_rd_wr", rf_rd_wr, 0);
        reset = 1'b0;
        ptr   = N - 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        check_eq("abort_no_rsp", nrsp, 0);
        run_txn(1, 2'b11, 3'd5, 3'd0, 16'h5A5A);

        // Both requesters held continuously.
        do_reset();
        @(negedge clk);
        set_fields(0, 2'b01, 3'd0, 3'd0, 16'h0);
        set_fields(1, 2'b01, 3'd1, 3'd0, 16'h0);
        bus.req = 2'b11;
        got     = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            #1;
            if (bus.gnt != '0) begin
                w = onehot_idx(bus.gnt);
                check_eq("arb_order", w, exp_winner(2'b11));
                ptr = w;
                got++;
            end
            @(negedge clk);
        end
        bus.req = '0;
        check_eq("arb_count", got, 4);
        for (int c = 0; c < 10 && bus.busy; c++) @(negedge clk);
        check_eq("arb_drain", bus.busy, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            run_txn(int'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
